// File: rtl/fp32_stream_source_32.sv
// fp32_stream_source_32: holds one frame of DEPTH float32 words written through a
// random-access port and, on start, streams them one word per cycle with
// valid/last to the 32-input FP32 adder. Words are passed bit-exact.
// Optional build macro: STREAM_BACKPRESSURE_EN adds i_ready flow control.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; frame buffer writable
// S_STREAM | emitting mem[0..DEPTH-1]; buffer write-protected
// S_DONE   | one-cycle o_done pulse after the last word; busy still high
module fp32_stream_source_32 #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_start,
`ifdef STREAM_BACKPRESSURE_EN
   input  logic                  i_ready,
`endif
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_last,
   output logic                  o_busy,
   output logic                  o_done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
   logic                    advance;

   // A held word (valid without ready) blocks the stream; an empty output never does.
`ifdef STREAM_BACKPRESSURE_EN
   assign advance = !valid_q || i_ready;
`else
   assign advance = 1'b1;
`endif

   // Next-state, frame buffer write and output register computation.
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      data_d   = data_q;
      valid_d  = valid_q;
      last_d   = last_q;
      busy_d   = busy_q;
      done_d   = done_q;
      mem_d    = mem_q;
      case (state_q)
         S_IDLE: begin
            // The write lands on the same edge as a start, so it is part of the frame.
            if (i_wr_en) begin
               mem_d[i_wr_addr] = i_wr_data;
            end
            if (i_start) begin
               state_d  = S_STREAM;
               rd_ptr_d = '0;
               busy_d   = 1'b1;
            end
         end
         S_STREAM: begin
            if (advance) begin
               if (last_q) begin
                  // rd_ptr has already wrapped to 0 here; no extra word is emitted.
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  data_d   = mem_q[rd_ptr_q];
                  valid_d  = 1'b1;
                  last_d   = (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1));
                  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State, pointer, outputs and buffer; reset abandons any frame and clears the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_last  = last_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;

endmodule
